controle_multiciclo: RTL and testbench
======================================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port opcode, input, 6 bits: instruction bits [31:26] from the instruction register.
REQ-004 The block SHALL have port memReady, input, 1 bit: memory access completes in the cycle it is high.
REQ-005 The block SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, outputs, 1 bit each: datapath controls.
REQ-006 The block SHALL have ports ALUSrcB, ALUOp, PCSource, outputs, 2 bits each: mux selects and ALU operation class.
REQ-007 The block SHALL have port estado, output, 4 bits: current state, for debug.
REQ-008 The block SHALL have port fimInstrucao, output, 1 bit: one-cycle pulse when an instruction retires.
REQ-009 The block SHALL have port opcodeInvalido, output, 1 bit: one-cycle pulse in DECODE for an unsupported opcode.

Function
REQ-010 The FSM SHALL have the states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=1 only when memReady=1; hold FETCH while memReady=0, go to DECODE when memReady=1.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state: 000000 goes to EXECUTE; 100011/101011 go to MEMADR; 000100 goes to BRANCH; 001000 goes to ADDIEX; 000010 goes to JUMP; any other opcode goes to FETCH with opcodeInvalido=1.
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to MEMREAD for lw, MEMWRITE for sw.
REQ-014 MEMREAD: MemRead=1, IorD=1; hold while memReady=0; go to MEMWB when memReady=1.
REQ-015 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, fimInstrucao=1; go to FETCH.
REQ-016 MEMWRITE: MemWrite=1, IorD=1; hold while memReady=0; when memReady=1 go to FETCH and assert fimInstrucao=1 in that cycle.
REQ-017 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; go to ALUWB.
REQ-018 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, fimInstrucao=1; go to FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, fimInstrucao=1; go to FETCH.
REQ-020 JUMP: PCWrite=1, PCSource=10, fimInstrucao=1; go to FETCH.
REQ-021 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to ADDIWB.
REQ-022 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, fimInstrucao=1; go to FETCH.
REQ-023 Any control not listed for a state SHALL be 0. Outputs SHALL be a Moore function of estado, except the memReady-gated IRWrite/PCWrite and the fimInstrucao in MEMWRITE.
REQ-024 opcode SHALL be sampled only in DECODE and MEMADR. Changes in opcode in any other state SHALL have no effect.
REQ-025 Latencies with memReady always 1 SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4; each cycle memReady=0 in FETCH/MEMREAD/MEMWRITE adds exactly one cycle.

Reset
REQ-026 While reset_n=0 the block SHALL hold estado=FETCH and drive every output to 0, asynchronously, including MemRead in FETCH.
REQ-027 The first rising edge after reset_n rises SHALL be evaluated as a FETCH cycle. Reset asserted mid-instruction SHALL abort it with no write strobe asserted afterwards.

Structure
REQ-028 State codes and opcode constants SHALL live in a shared header controle_defs.vh, also included by the datapath top and benches.
REQ-029 The next-state logic SHALL live in controle_multiciclo. A combinational output decoder controle_saidas (estado, memReady, opcode in; controls out) is the one permitted sub-module.

Verification
REQ-030 Reset: reset_n=0 asynchronously mid-MEMADR -> estado=0 and all outputs 0 immediately, before the next clock edge.
REQ-031 lw: opcode=100011, memReady=1 -> estados 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; fimInstrucao pulses once.
REQ-032 sw with wait: opcode=101011, memReady=0 for 3 cycles in MEMWRITE -> MemWrite high 4 cycles; fimInstrucao exactly once, on the memReady=1 cycle.
REQ-033 Fetch stall: memReady=0 for 2 cycles after reset -> IRWrite=PCWrite=0 for 2 cycles, then 1 for one cycle; estado goes to 1.
REQ-034 Sequence R-type(000000), beq(000100), j(000010), addi(001000) -> 4+3+3+4=14 cycles, 4 fimInstrucao pulses, PCSource=01 in BRANCH and 10 in JUMP.
REQ-035 Illegal opcode 111111 -> opcodeInvalido pulses in DECODE, no write strobe asserted, next state FETCH.

Source files
------------

// File: rtl/controle_multiciclo_pkg.sv
// Shared state codes, opcode constants and the control-word layout for the
// multicycle controller and its output decoder.
package controle_multiciclo_pkg;

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECUTE  = 4'd6;
   localparam logic [3:0] ALUWB    = 4'd7;
   localparam logic [3:0] BRANCH   = 4'd8;
   localparam logic [3:0] JUMP     = 4'd9;
   localparam logic [3:0] ADDIEX   = 4'd10;
   localparam logic [3:0] ADDIWB   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       fim_instrucao;
      logic       opcode_invalido;
   } controles_t;

   function automatic logic opcode_suportado(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/controle_saidas.sv
// Combinational control decoder: Moore outputs per state, plus the
// memReady-qualified fetch/store strobes and the illegal-opcode flag.
module controle_saidas
   import controle_multiciclo_pkg::*;
(
   input  logic [3:0] estado,
   input  logic       memReady,
   input  logic [5:0] opcode,
   output controles_t ctrl
);

   always_comb begin
      ctrl = '0;
      case (estado)
         FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.ir_write  = memReady;
            ctrl.pc_write  = memReady;
         end
         DECODE: begin
            ctrl.alu_src_b       = 2'b11;
            ctrl.opcode_invalido = !opcode_suportado(opcode);
         end
         MEMADR, ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
         end
         MEMREAD: begin
            ctrl.mem_read = 1'b1;
            ctrl.ior_d    = 1'b1;
         end
         MEMWB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.mem_to_reg    = 1'b1;
            ctrl.fim_instrucao = 1'b1;
         end
         MEMWRITE: begin
            ctrl.mem_write     = 1'b1;
            ctrl.ior_d         = 1'b1;
            ctrl.fim_instrucao = memReady;
         end
         EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = 2'b10;
         end
         ALUWB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.reg_dst       = 1'b1;
            ctrl.fim_instrucao = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = 2'b01;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
            ctrl.fim_instrucao = 1'b1;
         end
         JUMP: begin
            ctrl.pc_write      = 1'b1;
            ctrl.pc_source     = 2'b10;
            ctrl.fim_instrucao = 1'b1;
         end
         ADDIWB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.fim_instrucao = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset control FSM: holds the state register and next-state
// logic; output decoding is delegated to controle_saidas.
module controle_multiciclo
   import controle_multiciclo_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       memReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] estado,
   output logic       fimInstrucao,
   output logic       opcodeInvalido
);

   logic [3:0] estado_reg, estado_next;
   controles_t ctrl, ctrl_out;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) estado_reg <= FETCH;
      else          estado_reg <= estado_next;
   end

   always_comb begin
      estado_next = FETCH;
      case (estado_reg)
         FETCH:    estado_next = memReady ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_RTYPE:     estado_next = EXECUTE;
               OP_LW, OP_SW: estado_next = MEMADR;
               OP_BEQ:       estado_next = BRANCH;
               OP_ADDI:      estado_next = ADDIEX;
               OP_J:         estado_next = JUMP;
               default:      estado_next = FETCH;
            endcase
         end
         MEMADR:   estado_next = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  estado_next = memReady ? MEMWB : MEMREAD;
         MEMWRITE: estado_next = memReady ? FETCH : MEMWRITE;
         EXECUTE:  estado_next = ALUWB;
         ADDIEX:   estado_next = ADDIWB;
         default:  estado_next = FETCH;
      endcase
   end

   controle_saidas u_saidas (
      .estado   (estado_reg),
      .memReady (memReady),
      .opcode   (opcode),
      .ctrl     (ctrl)
   );

   // Reset forces every control low without waiting for a clock edge,
   // including the FETCH-state MemRead.
   assign ctrl_out = reset_n ? ctrl : '0;

   assign PCWrite        = ctrl_out.pc_write;
   assign PCWriteCond    = ctrl_out.pc_write_cond;
   assign IorD           = ctrl_out.ior_d;
   assign MemRead        = ctrl_out.mem_read;
   assign MemWrite       = ctrl_out.mem_write;
   assign MemtoReg       = ctrl_out.mem_to_reg;
   assign IRWrite        = ctrl_out.ir_write;
   assign ALUSrcA        = ctrl_out.alu_src_a;
   assign RegWrite       = ctrl_out.reg_write;
   assign RegDst         = ctrl_out.reg_dst;
   assign ALUSrcB        = ctrl_out.alu_src_b;
   assign ALUOp          = ctrl_out.alu_op;
   assign PCSource       = ctrl_out.pc_source;
   assign fimInstrucao   = ctrl_out.fim_instrucao;
   assign opcodeInvalido = ctrl_out.opcode_invalido;
   assign estado         = estado_reg;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: walks fetch stall, R/beq/j/addi,
// lw, sw with wait states, an illegal opcode and an asynchronous reset.
module tb_controle_multiciclo;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       memReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic       IRWrite, ALUSrcA, RegWrite, RegDst;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] estado;
   logic       fimInstrucao, opcodeInvalido;

   int passed = 0;
   int total  = 0;
   int fim_count = 0;
   int mw_count  = 0;

   always #5 clock = ~clock;

   controle_multiciclo dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .opcode         (opcode),
      .memReady       (memReady),
      .PCWrite        (PCWrite),
      .PCWriteCond    (PCWriteCond),
      .IorD           (IorD),
      .MemRead        (MemRead),
      .MemWrite       (MemWrite),
      .MemtoReg       (MemtoReg),
      .IRWrite        (IRWrite),
      .ALUSrcA        (ALUSrcA),
      .RegWrite       (RegWrite),
      .RegDst         (RegDst),
      .ALUSrcB        (ALUSrcB),
      .ALUOp          (ALUOp),
      .PCSource       (PCSource),
      .estado         (estado),
      .fimInstrucao   (fimInstrucao),
      .opcodeInvalido (opcodeInvalido)
   );

   // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
   // ALUSrcA RegWrite RegDst | ALUSrcB ALUOp PCSource | fim inval
   logic [17:0] outs;
   assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  ALUSrcA, RegWrite, RegDst, ALUSrcB, ALUOp, PCSource,
                  fimInstrucao, opcodeInvalido};

   localparam logic [17:0] E_ZERO       = 18'b0;
   localparam logic [17:0] E_FETCH_WAIT = {10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_FETCH_RDY  = {10'b1001001000, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_DECODE     = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_DECODE_INV = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b01};
   localparam logic [17:0] E_MEMADR     = {10'b0000000100, 2'b10, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_MEMREAD    = {10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_MEMWB      = {10'b0000010010, 2'b00, 2'b00, 2'b00, 2'b10};
   localparam logic [17:0] E_MEMWR_WAIT = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_MEMWR_RDY  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b10};
   localparam logic [17:0] E_EXECUTE    = {10'b0000000100, 2'b00, 2'b10, 2'b00, 2'b00};
   localparam logic [17:0] E_ALUWB      = {10'b0000000011, 2'b00, 2'b00, 2'b00, 2'b10};
   localparam logic [17:0] E_BRANCH     = {10'b0100000100, 2'b00, 2'b01, 2'b01, 2'b10};
   localparam logic [17:0] E_JUMP       = {10'b1000000000, 2'b00, 2'b00, 2'b10, 2'b10};
   localparam logic [17:0] E_ADDIWB     = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b10};

   always @(posedge clock) begin
      if (fimInstrucao) fim_count <= fim_count + 1;
      if (MemWrite)     mw_count  <= mw_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input string tag, input logic [3:0] exp_estado, input logic [17:0] exp_outs);
      @(negedge clock);
      #1;
      check({tag, "_estado"}, 32'(estado), 32'(exp_estado));
      check({tag, "_outs"}, 32'(outs), 32'(exp_outs));
      $display("step %s estado=%0d outs=%05h", tag, estado, outs);
   endtask

   initial begin
      reset_n  = 1'b0;
      memReady = 1'b0;
      opcode   = 6'b000000;
      #1;
      check("rst_estado", 32'(estado), 32'd0);
      check("rst_outs", 32'(outs), 32'(E_ZERO));

      // Fetch stall: two cycles with memReady low, then ready
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("stall1_outs", 32'(outs), 32'(E_FETCH_WAIT));
      step("stall2", 4'd0, E_FETCH_WAIT);
      @(negedge clock);
      memReady = 1'b1;
      opcode   = 6'b000000;
      #1;
      check("fetch_rdy_estado", 32'(estado), 32'd0);
      check("fetch_rdy_outs", 32'(outs), 32'(E_FETCH_RDY));

      // R-type, beq, j, addi back to back
      step("r_decode", 4'd1, E_DECODE);
      step("r_execute", 4'd6, E_EXECUTE);
      opcode = 6'b111111;  // ignored outside DECODE/MEMADR
      step("r_aluwb", 4'd7, E_ALUWB);
      step("beq_fetch", 4'd0, E_FETCH_RDY);
      opcode = 6'b000100;
      step("beq_decode", 4'd1, E_DECODE);
      step("beq_branch", 4'd8, E_BRANCH);
      step("j_fetch", 4'd0, E_FETCH_RDY);
      opcode = 6'b000010;
      step("j_decode", 4'd1, E_DECODE);
      step("j_jump", 4'd9, E_JUMP);
      step("addi_fetch", 4'd0, E_FETCH_RDY);
      opcode = 6'b001000;
      step("addi_decode", 4'd1, E_DECODE);
      step("addi_ex", 4'd10, E_MEMADR);
      step("addi_wb", 4'd11, E_ADDIWB);
      step("lw_fetch", 4'd0, E_FETCH_RDY);
      check("seq_fim_count", 32'(fim_count), 32'd4);

      // lw
      opcode = 6'b100011;
      step("lw_decode", 4'd1, E_DECODE);
      step("lw_memadr", 4'd2, E_MEMADR);
      step("lw_memread", 4'd3, E_MEMREAD);
      step("lw_memwb", 4'd4, E_MEMWB);
      step("sw_fetch", 4'd0, E_FETCH_RDY);
      check("lw_fim_count", 32'(fim_count), 32'd5);

      // sw with three wait cycles in MEMWRITE
      opcode = 6'b101011;
      step("sw_decode", 4'd1, E_DECODE);
      step("sw_memadr", 4'd2, E_MEMADR);
      memReady = 1'b0;
      step("sw_wait1", 4'd5, E_MEMWR_WAIT);
      step("sw_wait2", 4'd5, E_MEMWR_WAIT);
      step("sw_wait3", 4'd5, E_MEMWR_WAIT);
      @(negedge clock);
      memReady = 1'b1;
      #1;
      check("sw_rdy_outs", 32'(outs), 32'(E_MEMWR_RDY));
      step("ill_fetch", 4'd0, E_FETCH_RDY);
      check("sw_mw_count", 32'(mw_count), 32'd4);
      check("sw_fim_count", 32'(fim_count), 32'd6);

      // Illegal opcode
      opcode = 6'b111111;
      step("ill_decode", 4'd1, E_DECODE_INV);
      step("ill_back", 4'd0, E_FETCH_RDY);
      check("ill_fim_count", 32'(fim_count), 32'd6);

      // Asynchronous reset in the middle of MEMADR
      opcode = 6'b100011;
      step("ar_decode", 4'd1, E_DECODE);
      step("ar_memadr", 4'd2, E_MEMADR);
      #1;
      reset_n = 1'b0;
      #1;
      check("ar_estado", 32'(estado), 32'd0);
      check("ar_outs", 32'(outs), 32'(E_ZERO));
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("ar_fetch_outs", 32'(outs), 32'(E_FETCH_RDY));
      step("ar_decode2", 4'd1, E_DECODE);
      check("ar_mw_count", 32'(mw_count), 32'd4);
      check("ar_fim_count", 32'(fim_count), 32'd6);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
